// File: rtl/ita_step_sequencer.sv
// ITA step sequencer: latches a layer descriptor, walks the layer's step
// sequence, issues output-tile jobs with a bounded number in flight, drains
// between steps, and drives the per-step requant/activation constants.
package ita_step_pkg;

    typedef logic [7:0] requant_const_t;
    typedef logic [7:0] requant_t;
    typedef logic [3:0] n_heads_t;

    typedef enum logic [1:0] {
        ActIdentity = 2'd0,
        ActRelu     = 2'd1,
        ActGelu     = 2'd2
    } activation_e;

    typedef enum logic [1:0] {
        LayerAttention   = 2'd0,
        LayerFeedforward = 2'd1,
        LayerLinear      = 2'd2
    } layer_e;

    typedef enum logic [3:0] {
        StepIdle   = 4'd0,
        StepQ      = 4'd1,
        StepK      = 4'd2,
        StepV      = 4'd3,
        StepQK     = 4'd4,
        StepAV     = 4'd5,
        StepOW     = 4'd6,
        StepF1     = 4'd7,
        StepF2     = 4'd8,
        StepMatMul = 4'd9
    } step_e;

    typedef struct packed {
        logic                 start;
        layer_e               layer;
        activation_e          activation;
        logic [31:0]          tile_s;
        logic [31:0]          tile_e;
        logic [31:0]          tile_p;
        logic [31:0]          tile_f;
        requant_const_t [7:0] eps_mult;
        requant_const_t [7:0] right_shift;
        requant_t [7:0]       add;
    } ctrl_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// Tile job handshake: a job is transferred on every rising clock edge where
// tile_valid_o and tile_ready_i are both high; while valid is high and ready
// low, step, head and indices are held. tile_done_i is a one-cycle pulse per
// completed job, independent of the issue handshake.
module ita_step_sequencer
    import ita_step_pkg::*;
#(
    parameter int MaxOutstanding = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  ctrl_t          ctrl_i,
    input  n_heads_t       n_heads_i,
    output step_e          step_o,
    output logic           tile_valid_o,
    input  logic           tile_ready_i,
    output logic [31:0]    tile_outer_o,
    output logic [31:0]    tile_inner_o,
    output n_heads_t       head_o,
    input  logic           tile_done_i,
    output requant_const_t eps_mult_o,
    output requant_const_t right_shift_o,
    output requant_t       add_o,
    output activation_e    activation_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o,
    output logic [1:0]     dbg_state_o
);

    localparam int CntW = idx_width(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxOut = CntW'(MaxOutstanding);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2
    } state_e;

    state_e               r_state, w_state_nxt;
    step_e                r_step, w_step_nxt;
    n_heads_t             r_head, w_head_nxt;
    logic [31:0]          r_outer, w_outer_nxt;
    logic [31:0]          r_inner, w_inner_nxt;
    logic                 r_valid, w_valid_nxt;
    logic [CntW-1:0]      r_out, w_out_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_err, w_err_nxt;
    logic                 w_load;

    // latched descriptor
    n_heads_t             r_n_heads;
    activation_e          r_act;
    logic [31:0]          r_tile_s, r_tile_e, r_tile_p, r_tile_f;
    requant_const_t [7:0] r_eps;
    requant_const_t [7:0] r_rs;
    requant_t [7:0]       r_add;

    logic                 w_accept, w_spurious, w_final;
    logic                 w_inner_last, w_outer_last;
    logic [31:0]          w_inner_raw, w_inner_cnt, w_outer_cnt;
    n_heads_t             w_head_last;
    logic [2:0]           w_rq_idx;

    function automatic step_e first_step(input layer_e layer);
        case (layer)
            LayerAttention:   return StepQ;
            LayerFeedforward: return StepF1;
            default:          return StepMatMul;
        endcase
    endfunction

    assign w_accept     = r_valid & tile_ready_i;
    assign w_spurious   = tile_done_i & (r_out == '0) & ~w_accept;
    assign w_outer_cnt  = (r_tile_s == 32'd0) ? 32'd1 : r_tile_s;
    assign w_inner_cnt  = (w_inner_raw == 32'd0) ? 32'd1 : w_inner_raw;
    assign w_inner_last = (r_inner == w_inner_cnt - 32'd1);
    assign w_outer_last = (r_outer == w_outer_cnt - 32'd1);
    assign w_head_last  = (r_n_heads == '0) ? '0 : r_n_heads - n_heads_t'(1);
    assign w_final      = ((r_step == StepOW) && (r_head == w_head_last)) ||
                          (r_step == StepF2) || (r_step == StepMatMul);

    // Inner tile count and requant constant index selected by the current step
    always_comb begin
        w_inner_raw = r_tile_f;
        w_rq_idx    = 3'd0;
        case (r_step)
            StepQ:      begin w_inner_raw = r_tile_p; w_rq_idx = 3'd0; end
            StepK:      begin w_inner_raw = r_tile_p; w_rq_idx = 3'd1; end
            StepV:      begin w_inner_raw = r_tile_p; w_rq_idx = 3'd2; end
            StepQK:     begin w_inner_raw = r_tile_s; w_rq_idx = 3'd3; end
            StepAV:     begin w_inner_raw = r_tile_p; w_rq_idx = 3'd4; end
            StepOW:     begin w_inner_raw = r_tile_e; w_rq_idx = 3'd5; end
            StepF1:     begin w_inner_raw = r_tile_f; w_rq_idx = 3'd6; end
            StepF2:     begin w_inner_raw = r_tile_e; w_rq_idx = 3'd7; end
            StepMatMul: begin w_inner_raw = r_tile_f; w_rq_idx = 3'd6; end
            default:    begin w_inner_raw = r_tile_f; w_rq_idx = 3'd0; end
        endcase
    end

    // Next-state, tile walk, outstanding count and flags
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_head_nxt  = r_head;
        w_outer_nxt = r_outer;
        w_inner_nxt = r_inner;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err | w_spurious;
        w_load      = 1'b0;

        // issue and done together cancel; a spurious done never underflows
        w_out_nxt = r_out;
        if (w_accept && !tile_done_i) begin
            w_out_nxt = r_out + CntW'(1);
        end else if (!w_accept && tile_done_i && (r_out != '0)) begin
            w_out_nxt = r_out - CntW'(1);
        end

        case (r_state)
            StIdle: begin
                w_busy_nxt  = 1'b0;
                w_step_nxt  = StepIdle;
                w_head_nxt  = '0;
                w_outer_nxt = '0;
                w_inner_nxt = '0;
                if (ctrl_i.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = StIssue;
                    w_busy_nxt  = 1'b1;
                    w_step_nxt  = first_step(ctrl_i.layer);
                    w_err_nxt   = w_spurious;
                end
            end
            StIssue: begin
                if (w_accept) begin
                    if (w_inner_last) begin
                        w_inner_nxt = '0;
                        if (w_outer_last) begin
                            w_outer_nxt = '0;
                            w_state_nxt = StDrain;
                        end else begin
                            w_outer_nxt = r_outer + 32'd1;
                        end
                    end else begin
                        w_inner_nxt = r_inner + 32'd1;
                    end
                end
            end
            StDrain: begin
                // the last completion of the step advances in the same cycle
                if (w_out_nxt == '0) begin
                    w_outer_nxt = '0;
                    w_inner_nxt = '0;
                    if (w_final) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = StIdle;
                    end else begin
                        w_state_nxt = StIssue;
                        case (r_step)
                            StepQ:  w_step_nxt = StepK;
                            StepK:  w_step_nxt = StepV;
                            StepV:  w_step_nxt = StepQK;
                            StepQK: w_step_nxt = StepAV;
                            StepAV: w_step_nxt = StepOW;
                            StepOW: begin
                                w_step_nxt = StepQ;
                                w_head_nxt = r_head + n_heads_t'(1);
                            end
                            default: w_step_nxt = StepF2;
                        endcase
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        w_valid_nxt = (w_state_nxt == StIssue) && (w_out_nxt < MaxOut);
    end

    // FSM state and control registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_step  <= StepIdle;
            r_head  <= '0;
            r_outer <= '0;
            r_inner <= '0;
            r_valid <= 1'b0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_head  <= w_head_nxt;
            r_outer <= w_outer_nxt;
            r_inner <= w_inner_nxt;
            r_valid <= w_valid_nxt;
            r_out   <= w_out_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Descriptor capture on an accepted start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_n_heads <= '0;
            r_act     <= ActIdentity;
            r_tile_s  <= '0;
            r_tile_e  <= '0;
            r_tile_p  <= '0;
            r_tile_f  <= '0;
            r_eps     <= '0;
            r_rs      <= '0;
            r_add     <= '0;
        end else if (w_load) begin
            r_n_heads <= n_heads_i;
            r_act     <= ctrl_i.activation;
            r_tile_s  <= ctrl_i.tile_s;
            r_tile_e  <= ctrl_i.tile_e;
            r_tile_p  <= ctrl_i.tile_p;
            r_tile_f  <= ctrl_i.tile_f;
            r_eps     <= ctrl_i.eps_mult;
            r_rs      <= ctrl_i.right_shift;
            r_add     <= ctrl_i.add;
        end
    end

    // Per-step constants follow step_o; zero while no step is active
    always_comb begin
        eps_mult_o    = '0;
        right_shift_o = '0;
        add_o         = '0;
        activation_o  = ActIdentity;
        if (r_step != StepIdle) begin
            eps_mult_o    = r_eps[w_rq_idx];
            right_shift_o = r_rs[w_rq_idx];
            add_o         = r_add[w_rq_idx];
            if ((r_step == StepF1) || (r_step == StepMatMul)) begin
                activation_o = r_act;
            end
        end
    end

    assign step_o       = r_step;
    assign tile_valid_o = r_valid;
    assign tile_outer_o = r_outer;
    assign tile_inner_o = r_inner;
    assign head_o       = r_head;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_ita_step_sequencer.sv
// Testbench for ita_step_sequencer: vector table of layer shapes, hand-written
// corner sequences, and randomized layers checked against a job-list model.
module tb_ita_step_sequencer;
    import ita_step_pkg::*;

    localparam int MAX_OUT = 4;
    localparam int JW      = 72;

    // ---------------- clock / reset / DUT ----------------
    logic           clk_i = 1'b0;
    logic           rst_ni;
    ctrl_t          ctrl_i;
    n_heads_t       n_heads_i;
    step_e          step_o;
    logic           tile_valid_o;
    logic           tile_ready_i;
    logic [31:0]    tile_outer_o;
    logic [31:0]    tile_inner_o;
    n_heads_t       head_o;
    logic           tile_done_i;
    requant_const_t eps_mult_o;
    requant_const_t right_shift_o;
    requant_t       add_o;
    activation_e    activation_o;
    logic           busy_o;
    logic           done_o;
    logic           err_o;
    logic [1:0]     dbg_state_o;

    always #5 clk_i = ~clk_i;

    ita_step_sequencer #(.MaxOutstanding(MAX_OUT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ctrl_i(ctrl_i), .n_heads_i(n_heads_i),
        .step_o(step_o), .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
        .tile_outer_o(tile_outer_o), .tile_inner_o(tile_inner_o), .head_o(head_o),
        .tile_done_i(tile_done_i), .eps_mult_o(eps_mult_o), .right_shift_o(right_shift_o),
        .add_o(add_o), .activation_o(activation_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [JW-1:0] exp_q[$];
    // requant constant index per step code (Idle, Q, K, V, QK, AV, OW, F1, F2, MatMul)
    int rq_tab[10] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 6};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_step"},  step_o, StepIdle);
        check({tag, "_valid"}, tile_valid_o, 0);
        check({tag, "_busy"},  busy_o, 0);
        check({tag, "_done"},  done_o, 0);
        check({tag, "_err"},   err_o, 0);
        check({tag, "_idx"},   {tile_outer_o, tile_inner_o, head_o}, 0);
        check({tag, "_const"}, {eps_mult_o, right_shift_o, add_o, activation_o}, 0);
        check({tag, "_state"}, dbg_state_o, 0);
    endtask

    // Reference model: the full ordered job list of a layer
    task automatic build_jobs(input layer_e layer, input n_heads_t h, input int s, input int e,
                              input int p, input int f);
        step_e seq[$];
        int heads, s_eff, in_cnt;
        exp_q.delete();
        heads = 1;
        case (layer)
            LayerAttention: begin
                seq   = '{StepQ, StepK, StepV, StepQK, StepAV, StepOW};
                heads = (h == 0) ? 1 : int'(h);
            end
            LayerFeedforward: seq = '{StepF1, StepF2};
            default:          seq = '{StepMatMul};
        endcase
        s_eff = (s == 0) ? 1 : s;
        for (int hh = 0; hh < heads; hh++) begin
            foreach (seq[k]) begin
                case (seq[k])
                    StepQK:             in_cnt = s;
                    StepOW, StepF2:     in_cnt = e;
                    StepF1, StepMatMul: in_cnt = f;
                    default:            in_cnt = p;
                endcase
                if (in_cnt == 0) in_cnt = 1;
                for (int o = 0; o < s_eff; o++)
                    for (int i = 0; i < in_cnt; i++)
                        exp_q.push_back({4'(seq[k]), 4'(hh), 32'(o), 32'(i)});
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_ctrl(input layer_e layer, input n_heads_t h, input int s, input int e,
                            input int p, input int f, input activation_e act);
        ctrl_i.start      = 1'b0;
        ctrl_i.layer      = layer;
        ctrl_i.activation = act;
        ctrl_i.tile_s     = 32'(s);
        ctrl_i.tile_e     = 32'(e);
        ctrl_i.tile_p     = 32'(p);
        ctrl_i.tile_f     = 32'(f);
        for (int k = 0; k < 8; k++) begin
            ctrl_i.eps_mult[k]    = 8'($urandom);
            ctrl_i.right_shift[k] = 8'($urandom);
            ctrl_i.add[k]         = 8'($urandom);
        end
        n_heads_i = h;
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        ctrl_i.start = 1'b1;
        @(negedge clk_i);
        ctrl_i.start = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        tile_ready_i = 1'b0;
        tile_done_i  = 1'b0;
        ctrl_i.start = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Runs one complete layer with a randomized engine and scoreboards every job
    task automatic run_layer(input layer_e layer, input n_heads_t h, input int s, input int e,
                             input int p, input int f, input activation_e act, input int pct,
                             input int dmin, input int dmax, input int hold, output int n_tiles);
        int due_q[$];
        int inflight, cyc, n_total, idx;
        bit finished;
        logic [JW-1:0] exp_w, got_w;
        step_e st;
        set_ctrl(layer, h, s, e, p, f, act);
        build_jobs(layer, h, s, e, p, f);
        n_total = exp_q.size();
        tile_ready_i = 1'b0;
        tile_done_i  = 1'b0;
        pulse_start();
        check("start_busy", busy_o, 1);
        check("start_valid", tile_valid_o, 1);
        check("start_err_clear", err_o, 0);
        check("start_job", {step_o, head_o, tile_outer_o, tile_inner_o}, exp_q[0]);
        n_tiles = 0; inflight = 0; cyc = 0; finished = 0;
        while (!finished && cyc < 5000) begin
            if (done_o) begin
                finished = 1'b1;
                check("done_busy", busy_o, 1);
            end else begin
                if (tile_valid_o) check("valid_below_limit", inflight < MAX_OUT, 1);
                if (cyc < hold) begin
                    tile_ready_i = 1'b0;
                    check("hold_valid", tile_valid_o, 1);
                    check("hold_idx", {step_o, tile_outer_o, tile_inner_o}, {4'(exp_q[0][71:68]), 64'd0});
                end else begin
                    tile_ready_i = ($urandom_range(99) < pct);
                end
                if (tile_valid_o && tile_ready_i) begin
                    got_w = {step_o, head_o, tile_outer_o, tile_inner_o};
                    if (exp_q.size() == 0) begin
                        check("extra_tile", n_tiles + 1, n_total);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("tile", got_w, exp_w);
                        st  = step_e'(exp_w[71:68]);
                        idx = rq_tab[int'(st)];
                        check("eps_mult", eps_mult_o, ctrl_i.eps_mult[idx]);
                        check("right_shift", right_shift_o, ctrl_i.right_shift[idx]);
                        check("add", add_o, ctrl_i.add[idx]);
                        check("activation", activation_o,
                              (st == StepF1 || st == StepMatMul) ? act : ActIdentity);
                    end
                    n_tiles++;
                    inflight++;
                    due_q.push_back(cyc + 1 + int'($urandom_range(dmax, dmin)));
                end
                tile_done_i = 1'b0;
                if (due_q.size() > 0 && due_q[0] <= cyc) begin
                    void'(due_q.pop_front());
                    tile_done_i = 1'b1;
                    inflight--;
                end
            end
            if (!finished) begin
                @(negedge clk_i);
                cyc++;
            end
        end
        check("layer_done_seen", finished, 1);
        check("all_jobs_issued", exp_q.size(), 0);
        check("inflight_zero", inflight, 0);
        tile_ready_i = 1'b0;
        tile_done_i  = 1'b0;
        @(negedge clk_i);
        check("done_single", done_o, 0);
        check("idle_busy", busy_o, 0);
        check("idle_step", step_o, StepIdle);
        check("no_err", err_o, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        layer_e      layer;
        n_heads_t    heads;
        int          s, e, p, f;
        activation_e act;
        int          pct, dly, hold;
        int          exp_tiles;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int nt, acc, pend;
        bit found;
        rst_ni = 1'b0;
        ctrl_i = '0;
        n_heads_i = '0;
        tile_ready_i = 1'b0;
        tile_done_i  = 1'b0;

        vecs[0] = '{LayerLinear,      4'd0, 2, 1, 1, 3, ActRelu, 100, 1, 0, 6};
        vecs[1] = '{LayerAttention,   4'd2, 1, 1, 1, 1, ActGelu, 100, 1, 0, 12};
        vecs[2] = '{LayerFeedforward, 4'd1, 1, 1, 1, 2, ActGelu, 100, 1, 5, 3};
        vecs[3] = '{LayerLinear,      4'd0, 0, 0, 0, 0, ActRelu, 100, 1, 0, 1};
        vecs[4] = '{LayerAttention,   4'd0, 1, 1, 2, 1, ActRelu, 100, 0, 0, 10};
        vecs[5] = '{LayerAttention,   4'd3, 2, 1, 1, 5, ActRelu,  70, 2, 0, 42};
        vecs[6] = '{LayerFeedforward, 4'd1, 2, 3, 1, 2, ActRelu,  60, 2, 0, 10};

        repeat (3) @(negedge clk_i);
        check_reset_outputs("por");
        rst_ni = 1'b1;
        @(negedge clk_i);

        foreach (vecs[v]) begin
            run_layer(vecs[v].layer, vecs[v].heads, vecs[v].s, vecs[v].e, vecs[v].p, vecs[v].f,
                      vecs[v].act, vecs[v].pct, vecs[v].dly, vecs[v].dly, vecs[v].hold, nt);
            check($sformatf("vec%0d_tiles", v), nt, vecs[v].exp_tiles);
        end

        // spurious done while idle sets err; the next start clears it
        tile_done_i = 1'b1;
        @(negedge clk_i);
        tile_done_i = 1'b0;
        check("spurious_err", err_o, 1);
        @(negedge clk_i);
        check("spurious_err_sticky", err_o, 1);
        run_layer(LayerLinear, 4'd0, 0, 0, 0, 0, ActGelu, 100, 1, 1, 0, nt);
        check("after_spurious_tiles", nt, 1);

        // outstanding limit with completions withheld
        set_ctrl(LayerAttention, 4'd1, 1, 1, 8, 1, ActIdentity);
        tile_ready_i = 1'b1;
        pulse_start();
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            if (tile_valid_o && tile_ready_i) acc++;
            @(negedge clk_i);
        end
        check("limit_accepts", acc, 4);
        check("limit_valid_low", tile_valid_o, 0);
        tile_done_i = 1'b1;
        @(negedge clk_i);
        tile_done_i = 1'b0;
        check("limit_reenable", tile_valid_o, 1);
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            if (tile_valid_o && tile_ready_i) acc++;
            @(negedge clk_i);
        end
        check("limit_one_more", acc, 1);
        tile_done_i = 1'b1;
        @(negedge clk_i);
        check("limit_reenable2", tile_valid_o, 1);
        @(negedge clk_i);
        tile_done_i = 1'b0;
        check("issue_done_same_cycle_valid", tile_valid_o, 1);
        check("issue_done_same_cycle_inner", tile_inner_o, 6);
        apply_reset();

        // reset during QK of head 0, then a restart from the beginning
        set_ctrl(LayerAttention, 4'd1, 1, 1, 1, 1, ActIdentity);
        tile_ready_i = 1'b1;
        pulse_start();
        pend = 0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (step_o == StepQK) begin
                found = 1'b1;
            end else begin
                tile_done_i = pend[0];
                pend = (tile_valid_o && tile_ready_i) ? 1 : 0;
                @(negedge clk_i);
            end
        end
        check("reach_qk", found, 1);
        check("qk_head", head_o, 0);
        apply_reset();
        tile_done_i = 1'b1;
        @(negedge clk_i);
        tile_done_i = 1'b0;
        check("late_done_err", err_o, 1);
        run_layer(LayerAttention, 4'd1, 1, 1, 1, 1, ActRelu, 100, 0, 1, 0, nt);
        check("restart_tiles", nt, 6);

        // randomized layers
        for (int r = 0; r < 15; r++) begin
            int dmin;
            dmin = $urandom_range(2);
            run_layer(layer_e'($urandom_range(2)), n_heads_t'($urandom_range(3)),
                      $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3),
                      activation_e'($urandom_range(2)), $urandom_range(100, 30),
                      dmin, dmin + $urandom_range(3), 0, nt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
